serial_adder_ctrl: RTL and testbench

//   Bit-serial adder. Registers two WIDTH-bit operands and a carry-in, then

---
 rtl/serial_adder_ctrl.sv | 97 +++++++++
 tb/tb_serial_adder_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures two operands and a carry-in, then adds them
// LSB-first one bit per clock and assembles the parallel sum.
//
// state | meaning
// IDLE  | waiting for start; result/carry_out hold the last sum
// SHIFT | one operand bit pair consumed per clock
// DONE  | one-cycle done pulse; start here chains the next add directly
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             half_sum;
  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] result_next;

  // two half-add stages form the full-add bit cell
  assign half_sum  = a_sr[0] ^ b_sr[0];
  assign bit_sum   = half_sum ^ c;
  assign bit_carry = (a_sr[0] & b_sr[0]) | (half_sum & c);

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign result_next = bit_sum;
    end else begin : g_res_wn
      assign result_next = {bit_sum, result[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
    end else if (state == SHIFT) begin
      result <= result_next;
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      c      <= bit_carry;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST_BIT) begin
        carry_out <= bit_carry;
        state     <= DONE;
        busy      <= 1'b0;
        done      <= 1'b1;
      end
    end else begin
      // IDLE and DONE accept a start identically; any stray encoding recovers here too
      done <= 1'b0;
      if (start) begin
        a_sr   <= op_a;
        b_sr   <= op_b;
        c      <= carry_in;
        cnt    <= '0;
        result <= '0;
        state  <= SHIFT;
        busy   <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances checked every
// cycle against an arithmetic model, plus directed literal scenarios.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_s   = 2'b11;
  logic [1:0] start_s = 2'b00;
  logic [1:0] cin_s   = 2'b00;
  logic [7:0] a_s [2];
  logic [7:0] b_s [2];
  logic [1:0] busy_s, done_s, co_s;
  logic [7:0] res8;
  logic [0:0] res1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]),
    .op_a(a_s[0]), .op_b(b_s[0]), .carry_in(cin_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .result(res8), .carry_out(co_s[0])
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]),
    .op_a(a_s[1][0:0]), .op_b(b_s[1][0:0]), .carry_in(cin_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .result(res1), .carry_out(co_s[1])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  function automatic logic [7:0] mask(input int i);
    return (i == 0) ? 8'hFF : 8'h01;
  endfunction

  function automatic logic [7:0] dut_res(input int i);
    return (i == 0) ? res8 : {7'b0, res1};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: an accepted start fixes the full sum arithmetically; outputs follow
  // from how many busy cycles remain.
  int         m_left [2];
  logic       m_done [2];
  logic [7:0] m_res  [2];
  logic       m_co   [2];
  logic [8:0] m_pend [2];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst_s[i]) begin
        m_left[i] = 0;
        m_done[i] = 1'b0;
        m_res[i]  = 8'h00;
        m_co[i]   = 1'b0;
      end else if (m_left[i] > 0) begin
        m_left[i] = m_left[i] - 1;
        m_done[i] = (m_left[i] == 0);
        if (m_done[i]) begin
          m_res[i] = m_pend[i][7:0] & mask(i);
          m_co[i]  = m_pend[i][wid(i)];
        end
      end else begin
        m_done[i] = 1'b0;
        if (start_s[i]) begin
          m_pend[i] = {1'b0, a_s[i] & mask(i)} + {1'b0, b_s[i] & mask(i)} + {8'b0, cin_s[i]};
          m_res[i]  = 8'h00;
          m_left[i] = wid(i);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy[w%0d]", wid(i)), 16'(busy_s[i]), 16'(m_left[i] > 0));
      check($sformatf("done[w%0d]", wid(i)), 16'(done_s[i]), 16'(m_done[i]));
      if (m_left[i] == 0) begin
        check($sformatf("result[w%0d]", wid(i)), 16'(dut_res(i)), 16'(m_res[i]));
        check($sformatf("carry_out[w%0d]", wid(i)), 16'(co_s[i]), 16'(m_co[i]));
      end
    end
  end

  // Drive start for one edge; returns at the negedge after the accepting edge.
  task automatic pulse_start(input int i, input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    start_s[i] = 1'b1;
    a_s[i]     = a;
    b_s[i]     = b;
    cin_s[i]   = cin;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!done_s[i] && lat < 40) begin
      if (busy_s[i]) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!done_s[i]) check("done timeout", 16'(0), 16'(1));
  endtask

  task automatic add_chk(input string nm, input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] er, input logic ec);
    int lat, nb;
    pulse_start(i, a, b, cin);
    wait_done(i, lat, nb);
    check({nm, " latency"}, 16'(lat), 16'(wid(i)));
    check({nm, " busy cycles"}, 16'(nb), 16'(wid(i)));
    check({nm, " result"}, 16'(dut_res(i)), 16'(er));
    check({nm, " carry_out"}, 16'(co_s[i]), 16'(ec));
    check({nm, " model result"}, 16'(m_res[i]), 16'(er));
    check({nm, " model carry"}, 16'(m_co[i]), 16'(ec));
  endtask

  initial begin
    int lat, nb, ndone, t1, t2;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rs;
    a_s[0] = 8'h00; b_s[0] = 8'h00;
    a_s[1] = 8'h00; b_s[1] = 8'h00;

    repeat (2) @(negedge clk);
    check("reset busy", 16'(busy_s), 16'(0));
    check("reset done", 16'(done_s), 16'(0));
    check("reset result8", 16'(res8), 16'(0));
    check("reset carry", 16'(co_s), 16'(0));
    rst_s = 2'b00;

    add_chk("05+03", 0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    add_chk("FF+01", 0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add_chk("FF+FF+1", 0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    add_chk("00+00+1", 0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    add_chk("w1 1+1+1", 1, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1);
    add_chk("w1 1+0+0", 1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0);

    // start re-pulsed mid-add with different operands
    pulse_start(0, 8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    pulse_start(0, 8'hAA, 8'hBB, 1'b1);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_s[0]) begin
        ndone++;
        check("ignored start result", 16'(res8), 16'(8'h46));
        check("ignored start carry", 16'(co_s[0]), 16'(0));
      end
    end
    check("ignored start done pulses", 16'(ndone), 16'(1));

    // start held through DONE: back-to-back adds
    @(negedge clk);
    start_s[0] = 1'b1; a_s[0] = 8'h81; b_s[0] = 8'h7F; cin_s[0] = 1'b0;
    @(negedge clk);
    a_s[0] = 8'h3C; b_s[0] = 8'h0F; cin_s[0] = 1'b1;
    wait_done(0, lat, nb);
    t1 = cyc;
    check("b2b first result", 16'(res8), 16'(8'h00));
    check("b2b first carry", 16'(co_s[0]), 16'(1));
    @(negedge clk);
    start_s[0] = 1'b0;
    check("b2b no idle gap", 16'(busy_s[0]), 16'(1));
    wait_done(0, lat, nb);
    t2 = cyc;
    check("b2b done spacing", 16'(t2 - t1), 16'(9));
    check("b2b second result", 16'(res8), 16'(8'h4C));
    check("b2b second carry", 16'(co_s[0]), 16'(0));

    // reset during the 4th SHIFT cycle
    pulse_start(0, 8'h55, 8'h22, 1'b0);
    repeat (3) @(negedge clk);
    check("mid-add busy", 16'(busy_s[0]), 16'(1));
    rst_s[0] = 1'b1;
    @(negedge clk);
    check("mid reset busy", 16'(busy_s[0]), 16'(0));
    check("mid reset done", 16'(done_s[0]), 16'(0));
    check("mid reset result", 16'(res8), 16'(0));
    check("mid reset carry", 16'(co_s[0]), 16'(0));
    rst_s[0] = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_s[0]) ndone++;
    end
    check("mid reset no done", 16'(ndone), 16'(0));
    add_chk("after reset 55+22", 0, 8'h55, 8'h22, 1'b0, 8'h77, 1'b0);

    // random adds on both widths
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = 8'($urandom) & mask(i);
        rb = 8'($urandom) & mask(i);
        rc = 1'($urandom);
        rs = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
        pulse_start(i, ra, rb, rc);
        wait_done(i, lat, nb);
        if (dut_res(i) !== (rs[7:0] & mask(i)) || co_s[i] !== rs[wid(i)])
          check($sformatf("random w%0d %0h+%0h+%0h", wid(i), ra, rb, rc),
                16'({co_s[i], dut_res(i)}), 16'({rs[wid(i)], rs[7:0] & mask(i)}));
        else
          n_checks++;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
